fetch_unit_pq: RTL and testbench



---
 rtl/fetch_unit_pq.sv | 141 ++++++++++++++
 tb/tb_fetch_unit_pq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_pq.sv
// fetch_unit_pq: instruction fetch unit with a prefetch queue.
// Issues in-order reads to program memory from a wrapping fetch PC. Several
// reads may be outstanding at once. Returned words go into a small circular
// queue of {pc, instr} pairs, which decode drains.
//
// Handshakes:
//  - Memory request: a read is accepted on a cycle with pm_req && pm_gnt.
//  - Memory response: responses return in order, one per pm_rvalid cycle.
//  - Decode: the head is consumed on a cycle with fetch_valid && fetch_ready.
//  - Requests are issued only while queue occupancy plus outstanding reads is
//    below QDEPTH, so every response always has a free slot.
//  - A redirect flushes the queue. In FLUSH, responses for reads issued before
//    the redirect are drained and discarded.
module fetch_unit_pq #(
  parameter int ADDR_W   = 5,
  parameter int INSTR_W  = 32,
  parameter int QDEPTH   = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       pm_req,
  output logic [ADDR_W-1:0]          pm_addr,
  input  logic                       pm_gnt,
  input  logic                       pm_rvalid,
  input  logic [INSTR_W-1:0]         pm_rdata,
  output logic                       fetch_valid,
  input  logic                       fetch_ready,
  output logic [INSTR_W-1:0]         fetch_instr,
  output logic [ADDR_W-1:0]          fetch_pc,
  output logic [$clog2(QDEPTH):0]    q_count,
  output logic                       dbg_state
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int PW = $clog2(QDEPTH);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  typedef enum logic {S_FETCH = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   fpc, rpc;
  logic [CW-1:0]       outst, outst_nxt, count;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]   q_pc    [QDEPTH];
  logic [INSTR_W-1:0]  q_instr [QDEPTH];

  logic room, grant, rsp, push, pop;

  // Occupancy plus in-flight reads decides whether another read fits
  assign room  = ({1'b0, count} + {1'b0, outst}) < (CW+1)'(QDEPTH);
  assign grant = pm_req && pm_gnt;
  // A response with nothing outstanding is a protocol error and is ignored
  assign rsp   = pm_rvalid && (outst != '0);
  assign push  = rsp && (state == S_FETCH) && !redirect_valid;
  assign pop   = fetch_valid && fetch_ready;

  // Outstanding-read count after this cycle (grant and response may coincide)
  always_comb begin
    outst_nxt = outst;
    if (grant && !rsp)      outst_nxt = outst + CW'(1);
    else if (!grant && rsp) outst_nxt = outst - CW'(1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next state: stay in FLUSH until every pre-redirect read has returned
  always_comb begin
    state_nxt = state;
    if (redirect_valid || (state == S_FLUSH))
      state_nxt = (outst_nxt != '0) ? S_FLUSH : S_FETCH;
  end

  // FSM outputs: requests only in FETCH, never in a redirect cycle or in reset
  always_comb begin
    pm_req    = rst_n && (state == S_FETCH) && !redirect_valid && room;
    pm_addr   = fpc;
    dbg_state = state;
  end

  // Fetch PC, response PC and outstanding-read counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc   <= RST_PC;
      rpc   <= RST_PC;
      outst <= '0;
    end else begin
      outst <= outst_nxt;
      if (redirect_valid) begin
        fpc <= redirect_addr;
        rpc <= redirect_addr;
      end else begin
        if (grant) fpc <= fpc + ADDR_W'(1);
        if (push)  rpc <= rpc + ADDR_W'(1);
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Queue storage; reset so the head reads {RESET_PC, 0} while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= RST_PC;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]    <= rpc;
      q_instr[wr_ptr] <= pm_rdata;
    end
  end

  assign fetch_valid = (count != '0);
  assign fetch_instr = q_instr[rd_ptr];
  assign fetch_pc    = q_pc[rd_ptr];
  assign q_count     = count;

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Bench for fetch_unit_pq. A behavioural program memory answers grants in
// order after a programmable latency. An expected queue of PCs checks every
// word that decode pops. A cycle table covers start-up and back-pressure.
// Hand sequences cover flush, wrap, a coincident redirect, and mid-run reset.
module tb_fetch_unit_pq;

  localparam int ADDR_W = 5;
  localparam int INSTR_W = 32;
  localparam int QDEPTH = 4;
  localparam int CW = 3;

  logic               clk, rst_n;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               pm_req, pm_gnt, pm_rvalid;
  logic [ADDR_W-1:0]  pm_addr;
  logic [INSTR_W-1:0] pm_rdata;
  logic               fetch_valid, fetch_ready;
  logic [INSTR_W-1:0] fetch_instr;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [CW-1:0]      q_count;
  logic               dbg_state;

  fetch_unit_pq #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .pm_req(pm_req), .pm_addr(pm_addr), .pm_gnt(pm_gnt),
    .pm_rvalid(pm_rvalid), .pm_rdata(pm_rdata),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .q_count(q_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;
  int pops_seen = 0;
  logic gnt_en = 1'b1;
  logic inject_stray = 1'b0;
  int pend_due[$];
  logic [ADDR_W-1:0] pend_addr[$];
  logic [ADDR_W-1:0] exp_q[$];

  // values sampled inside the most recent cycle
  logic s_req, s_fv, s_state;
  logic [ADDR_W-1:0] s_addr, s_pc;
  logic [INSTR_W-1:0] s_instr;
  logic [CW-1:0] s_cnt;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {8'hA5, 3'b101, a, 11'h000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_exp(input logic [ADDR_W-1:0] start, input int n);
    logic [ADDR_W-1:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + ADDR_W'(1);
    end
  endtask

  // ---------------- driver: one clock cycle, entered and left at negedge ----------------
  task automatic step();
    int d;
    logic [ADDR_W-1:0] e;
    if (inject_stray) begin
      pm_rvalid = 1'b1;
      pm_rdata = 32'hDEAD_BEEF;
      inject_stray = 1'b0;
    end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      pm_rvalid = 1'b1;
      pm_rdata = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end else begin
      pm_rvalid = 1'b0;
      pm_rdata = '0;
    end
    #1;
    s_req = pm_req; s_addr = pm_addr; s_fv = fetch_valid; s_pc = fetch_pc;
    s_instr = fetch_instr; s_cnt = q_count; s_state = dbg_state;
    pm_gnt = gnt_en && pm_req;
    if (pm_gnt) begin
      d = cyc + lat;
      if (pend_due.size() > 0 && d <= pend_due[pend_due.size()-1])
        d = pend_due[pend_due.size()-1] + 1;
      pend_due.push_back(d);
      pend_addr.push_back(pm_addr);
    end
    // scoreboard: every word decode takes must be the next expected PC
    if (s_fv && fetch_ready) begin
      pops_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pop_unexpected: got pc %0d expected no pop (cycle %0d)", s_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", s_pc, e);
        chk("pop_instr", s_instr, mem_word(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic release_reset();
    pend_due.delete();
    pend_addr.delete();
    pm_rvalid = 1'b0;
    pm_gnt = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pm_req"}, pm_req, 0);
    chk({tag, "_fetch_valid"}, fetch_valid, 0);
    chk({tag, "_fetch_instr"}, fetch_instr, 0);
    chk({tag, "_fetch_pc"}, fetch_pc, 0);
    chk({tag, "_q_count"}, q_count, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- start-up / back-pressure vector table ----------------
  typedef struct {
    logic              ready;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              fv;
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic set_vec(input int i, input logic r, input logic q, input int a,
                         input logic v, input int p, input int c);
    tbl[i].ready = r; tbl[i].req = q; tbl[i].addr = ADDR_W'(a);
    tbl[i].fv = v; tbl[i].pc = ADDR_W'(p); tbl[i].cnt = CW'(c);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    pm_gnt = 1'b0;
    pm_rvalid = 1'b0;
    pm_rdata = '0;
    fetch_ready = 1'b0;

    //     idx rdy req addr fv pc cnt
    set_vec(0,  1, 1, 0,  0, 0, 0);
    set_vec(1,  1, 1, 1,  0, 0, 0);
    set_vec(2,  1, 1, 2,  1, 0, 1);
    set_vec(3,  1, 1, 3,  1, 1, 1);
    set_vec(4,  1, 1, 4,  1, 2, 1);
    set_vec(5,  1, 1, 5,  1, 3, 1);
    set_vec(6,  0, 1, 6,  1, 4, 1);
    set_vec(7,  0, 1, 7,  1, 4, 2);
    set_vec(8,  0, 0, 8,  1, 4, 3);
    set_vec(9,  0, 0, 8,  1, 4, 4);
    set_vec(10, 0, 0, 8,  1, 4, 4);
    set_vec(11, 0, 0, 8,  1, 4, 4);
    set_vec(12, 1, 0, 8,  1, 4, 4);
    set_vec(13, 1, 1, 8,  1, 5, 3);
    set_vec(14, 1, 1, 9,  1, 6, 2);
    set_vec(15, 1, 1, 10, 1, 7, 2);
    set_vec(16, 1, 1, 11, 1, 8, 2);
    set_vec(17, 1, 1, 12, 1, 9, 2);

    // reset values while rst_n is low
    @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);

    // T1: start-up, 1-cycle memory latency, then queue saturation and drain
    lat = 1; gnt_en = 1'b1;
    load_exp(0, 64);
    release_reset();
    for (int i = 0; i < 18; i++) begin
      fetch_ready = tbl[i].ready;
      step();
      chk($sformatf("tbl%0d_pm_req", i), s_req, tbl[i].req);
      chk($sformatf("tbl%0d_pm_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_fetch_valid", i), s_fv, tbl[i].fv);
      chk($sformatf("tbl%0d_q_count", i), s_cnt, tbl[i].cnt);
      if (tbl[i].fv) begin
        chk($sformatf("tbl%0d_fetch_pc", i), s_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_fetch_instr", i), s_instr, mem_word(tbl[i].pc));
      end
    end
    chk("tbl_pops", pops_seen, 10);

    // T2: redirect to 12 with two reads in flight (3-cycle latency)
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    lat = 3; fetch_ready = 1'b1;
    release_reset();
    step();
    chk("fl_c0_req", s_req, 1);
    step();
    chk("fl_c1_req", s_req, 1);
    chk("fl_c1_addr", s_addr, 1);
    redirect_valid = 1'b1; redirect_addr = 5'd12;
    step();
    chk("fl_redirect_req", s_req, 0);
    load_exp(12, 64);
    step();
    chk("fl_c3_state", s_state, 1);
    chk("fl_c3_req", s_req, 0);
    chk("fl_c3_cnt", s_cnt, 0);
    step();
    chk("fl_c4_state", s_state, 1);
    chk("fl_c4_req", s_req, 0);
    step();
    chk("fl_c5_state", s_state, 0);
    chk("fl_c5_req", s_req, 1);
    chk("fl_c5_addr", s_addr, 12);
    p0 = pops_seen;
    for (int i = 0; i < 8; i++) step();
    chk("fl_resumed", (pops_seen > p0), 1);

    // T3: drain, then best-case redirect latency across the PC wrap
    gnt_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    gnt_en = 1'b1; lat = 1;
    redirect_valid = 1'b1; redirect_addr = 5'd30;
    step();
    chk("wr_redirect_req", s_req, 0);
    load_exp(30, 64);
    step();
    chk("wr_n1_req", s_req, 1);
    chk("wr_n1_addr", s_addr, 30);
    chk("wr_n1_state", s_state, 0);
    step();
    chk("wr_n2_fv", s_fv, 0);
    step();
    chk("wr_n3_fv", s_fv, 1);
    chk("wr_n3_pc", s_pc, 30);
    for (int i = 1; i <= 3; i++) begin
      logic [ADDR_W-1:0] w;
      w = ADDR_W'(30 + i);
      step();
      chk($sformatf("wr_n%0d_fv", i + 3), s_fv, 1);
      chk($sformatf("wr_n%0d_pc", i + 3), s_pc, w);
    end

    // T4: redirect coincident with a pop and with a returning word
    p0 = pops_seen;
    redirect_valid = 1'b1; redirect_addr = 5'd5;
    step();
    chk("co_pop_fv", s_fv, 1);
    chk("co_pop_taken", pops_seen - p0, 1);
    load_exp(5, 64);
    step();
    chk("co_n1_cnt", s_cnt, 0);
    chk("co_n1_fv", s_fv, 0);
    chk("co_n1_state", s_state, 0);
    chk("co_n1_req", s_req, 1);
    chk("co_n1_addr", s_addr, 5);
    step();
    step();
    chk("co_n3_fv", s_fv, 1);
    chk("co_n3_pc", s_pc, 5);

    // T5: fill the queue, reset mid-run, stray response after release
    fetch_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mr_full_cnt", s_cnt, 4);
    chk("mr_full_req", s_req, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mr");
    @(negedge clk);
    load_exp(0, 64);
    fetch_ready = 1'b1;
    gnt_en = 1'b0;
    release_reset();
    inject_stray = 1'b1;
    step();
    chk("mr_c0_cnt", s_cnt, 0);
    chk("mr_c0_req", s_req, 1);
    chk("mr_c0_addr", s_addr, 0);
    gnt_en = 1'b1;
    step();
    chk("mr_c1_cnt", s_cnt, 0);
    chk("mr_c1_fv", s_fv, 0);
    chk("mr_c1_addr", s_addr, 0);
    step();
    step();
    chk("mr_c3_fv", s_fv, 1);
    chk("mr_c3_pc", s_pc, 0);
    chk("mr_c3_instr", s_instr, mem_word(0));
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
